cpu_ctrl_mc: RTL

Multi-cycle, parametrised successor to the accumulator-CPU controller.
- Sequences FETCH -> DECODE -> EXEC (-> IMM for immediate jumps) with an instruction-fetch ready handshake.
- Evaluates Z/C conditional jumps and supports HALT.
- A fetch-timeout counter flags a stalled instruction memory.
- Drives IR/PC/register-file/accumulator/ALU controls of the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/cpu_ctrl_timeout.sv | 47 ++++
 rtl/cpu_ctrl_mc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle accumulator-CPU controller:
// FSM states, opcode classes, ALU select codes and accumulator source codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IMM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_MOVA = 4'h5;
  localparam logic [3:0] OP_JZR  = 4'h6;
  localparam logic [3:0] OP_JZI  = 4'h7;
  localparam logic [3:0] OP_JCR  = 4'h8;
  localparam logic [3:0] OP_JCI  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;

  localparam logic [1:0] ACC_HOLD = 2'b00;
  localparam logic [1:0] ACC_REG  = 2'b01;
  localparam logic [1:0] ACC_ALU  = 2'b10;

  // Immediate jumps need a second bus word, so they go through S_IMM.
  function automatic logic is_imm_jump(input logic [3:0] op);
    return (op == OP_JZI) || (op == OP_JCI);
  endfunction

endpackage

// File: rtl/cpu_ctrl_timeout.sv
// Wait-cycle counter for bus handshakes: counts enabled cycles since the last
// clear and flags expiry on the TIMEOUT-th one. TIMEOUT=0 removes the counter.
module cpu_ctrl_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          at_limit;

      assign at_limit = (cnt_q == CW'(TIMEOUT - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && !at_limit) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Expires while waiting in the cycle that would be wait number TIMEOUT.
      assign expired = en && at_limit;
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, srst, clr, en};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_ctrl_mc.sv
// Multi-cycle accumulator-CPU controller: FETCH/DECODE/EXEC/IMM/HALT sequencer.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal opcode classes into HALT.
module cpu_ctrl_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW     = 8,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            CLB,
  input  logic            Z,
  input  logic            C,
  input  logic [OPW-1:0]  Opcode,
  input  logic            IrValid,
  output logic            LoadIR,
  output logic            IncPC,
  output logic            SelPC,
  output logic            LoadPC,
  output logic            LoadReg,
  output logic            LoadAcc,
  output logic [1:0]      SelAcc,
  output logic [ALUW-1:0] SelALU,
  output logic            Halted,
  output logic            FetchErr,
  output logic            Illegal
);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic       fetch_err_q, fetch_err_d;
  logic       illegal_d;
  logic [3:0] alu_sel;
  logic       wait_en, wait_clr, wait_expired;
  logic       imm_take;

  logic unused_opcode_low;
  assign unused_opcode_low = ^Opcode[OPW-5:0];

  assign wait_en  = ((state_q == S_FETCH) || (state_q == S_IMM)) && !IrValid;
  assign wait_clr = (state_d != state_q);
  assign imm_take = (op_q == OP_JZI) ? z_q : c_q;

  cpu_ctrl_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (CLK),
    .srst    (CLB),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_ff @(posedge CLK) begin
    if (CLB) begin
      state_q     <= S_RESET;
      op_q        <= OP_NOP;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      z_q         <= z_d;
      c_q         <= c_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Strobes come from the registered state; only the bus-word strobes in
  // FETCH/IMM are qualified by IrValid so they fire in the handshake cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    z_d         = z_q;
    c_d         = c_q;
    fetch_err_d = fetch_err_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    illegal_d   = Illegal;
`else
    illegal_d   = 1'b0;
`endif
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = ACC_HOLD;
    alu_sel = ALU_PASS;
    Halted  = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        if (IrValid) begin
          LoadIR  = 1'b1;
          IncPC   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end
      end

      S_DECODE: begin
        op_d    = Opcode[OPW-1:OPW-4];
        z_d     = Z;
        c_d     = C;
        state_d = is_imm_jump(Opcode[OPW-1:OPW-4]) ? S_IMM : S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_ADD: begin alu_sel = ALU_ADD; SelAcc = ACC_ALU; LoadAcc = 1'b1; end
          OP_SUB: begin alu_sel = ALU_SUB; SelAcc = ACC_ALU; LoadAcc = 1'b1; end
          OP_NOR: begin alu_sel = ALU_NOR; SelAcc = ACC_ALU; LoadAcc = 1'b1; end
          OP_MOVR: begin SelAcc = ACC_REG; LoadAcc = 1'b1; end
          OP_MOVA: LoadReg = 1'b1;
          OP_JZR: begin SelPC = 1'b1; LoadPC = z_q; end
          OP_JCR: begin SelPC = 1'b1; LoadPC = c_q; end
          OP_HALT: state_d = S_HALT;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            if ((op_q >= 4'hA) && (op_q <= 4'hE)) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
`endif
          end
        endcase
      end

      S_IMM: begin
        if (IrValid) begin
          state_d = S_FETCH;
          if (imm_take) begin
            LoadPC = 1'b1;
          end else begin
            IncPC = 1'b1;
          end
        end else if (wait_expired) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end
      end

      S_HALT: Halted = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge CLK) begin
    if (CLB) begin
      Illegal <= 1'b0;
    end else begin
      Illegal <= illegal_d;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
  assign Illegal        = 1'b0;
`endif

  assign SelALU   = ALUW'(alu_sel);
  assign FetchErr = fetch_err_q;

endmodule
